// File: rtl/det_frame_ctrl_if.sv
// Bundle between a frame requester, the frame controller and the attached 1011 detector.
// start is a request taken only while busy=0; done pulses once when the frame ends.
interface det_frame_ctrl_if #(
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 5
);
    logic               start;
    logic [FRAME_W-1:0] frame_in;
    logic               abort;
    logic               pat_dec;
    logic               det_clr;
    logic               det_valid;
    logic               det_data;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output start, frame_in, abort, pat_dec,
        input  det_clr, det_valid, det_data, busy, done, match_cnt
    );

    modport slave (
        input  start, frame_in, abort, pat_dec,
        output det_clr, det_valid, det_data, busy, done, match_cnt
    );
endinterface

// File: rtl/det_frame_ctrl.sv
// Serialises a frame MSB-first into a 1011 detector, counts its matches and reports per frame.
// Each bit is one SEND cycle followed by GAP idle cycles; matches are sampled in the first idle cycle.
module det_frame_ctrl #(
    parameter int FRAME_W = 16,
    parameter int GAP     = 1,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    det_frame_ctrl_if.slave  bus,
    output logic [2:0]       state_dbg
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        SEND = 3'd2,
        GAPW = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int              BW       = $clog2(FRAME_W + 1);
    localparam logic [3:0]      GAP_LAST = 4'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [BW-1:0]      bits_left;
    logic [3:0]         gap_cnt;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   run_cnt_nxt;

    // The detector's registered match shows up in the first idle cycle after a bit.
    always_comb begin
        run_cnt_nxt = run_cnt;
        if (state == GAPW && gap_cnt == 4'd0 && bus.pat_dec && run_cnt != CNT_MAX)
            run_cnt_nxt = run_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bits_left     <= '0;
            gap_cnt       <= '0;
            run_cnt       <= '0;
            bus.det_clr   <= 1'b0;
            bus.det_valid <= 1'b0;
            bus.det_data  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.match_cnt <= '0;
        end else if (state != IDLE && bus.abort) begin
            state         <= IDLE;
            bus.det_clr   <= 1'b1;
            bus.det_valid <= 1'b0;
            bus.det_data  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.det_clr   <= 1'b0;
            bus.det_valid <= 1'b0;
            bus.det_data  <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= CLR;
                        shreg       <= bus.frame_in;
                        bits_left   <= BW'(FRAME_W);
                        run_cnt     <= '0;
                        bus.busy    <= 1'b1;
                        bus.det_clr <= 1'b1;
                    end
                end
                CLR: begin
                    state         <= SEND;
                    bus.det_valid <= 1'b1;
                    bus.det_data  <= shreg[FRAME_W-1];
                    shreg         <= {shreg[FRAME_W-2:0], 1'b0};
                    bits_left     <= bits_left - BW'(1);
                end
                SEND: begin
                    state   <= GAPW;
                    gap_cnt <= '0;
                end
                GAPW: begin
                    run_cnt <= run_cnt_nxt;
                    if (gap_cnt == GAP_LAST) begin
                        if (bits_left != '0) begin
                            state         <= SEND;
                            bus.det_valid <= 1'b1;
                            bus.det_data  <= shreg[FRAME_W-1];
                            shreg         <= {shreg[FRAME_W-2:0], 1'b0};
                            bits_left     <= bits_left - BW'(1);
                        end else begin
                            // Use the next-count so a match in the final idle cycle is reported.
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.match_cnt <= run_cnt_nxt;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;
endmodule

// File: doc/det_frame_ctrl.md
DET_FRAME_CTRL -- requirements
Module: det_frame_ctrl

Interface
REQ-001 Parameter FRAME_W, default 16, frame length in bits.
REQ-002 Parameter GAP, default 1, idle cycles after each bit; legal range 1..15.
REQ-003 Parameter CNT_W, default 5, width of match_cnt.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-007 start  in  1  request to process one frame.
REQ-008 frame_in  in  FRAME_W  frame word, sent MSB first.
REQ-009 abort  in  1  cancel the frame in progress.
REQ-010 pat_dec  in  1  match output of the attached 1011 overlapping Mealy detector.
REQ-011 det_clr  out  1  synchronous active-high clear to the detector.
REQ-012 det_valid  out  1  bit-valid strobe to the detector.
REQ-013 det_data  out  1  serial bit to the detector.
REQ-014 busy  out  1  frame in progress.
REQ-015 done  out  1  one-cycle end-of-frame pulse.
REQ-016 match_cnt  out  CNT_W  detections in the last completed frame.

Function
REQ-017 FSM states: IDLE, CLR, SEND, GAPW, DONE.
REQ-018 IDLE: start=1 -> latch frame_in into shift register, clear the running count, go to CLR; otherwise stay in IDLE.
REQ-019 CLR: one cycle; det_clr=1; go to SEND.
REQ-020 SEND: one cycle; det_valid=1; det_data = current MSB of the shift register; shift left by one; decrement bits-remaining; go to GAPW.
REQ-021 GAPW: exactly GAP cycles; det_valid=0; det_data=0. After the last GAP cycle: go to SEND if bits remain, else go to DONE.
REQ-022 DONE: one cycle; done=1; copy the running count to match_cnt; go to IDLE.
REQ-023 Detection capture: running count +1 when pat_dec=1 in the first GAPW cycle after each SEND; pat_dec in every other cycle is ignored.
REQ-024 Running count saturates at 2^CNT_W-1.
REQ-025 busy=1 in CLR, SEND, GAPW and DONE; busy=0 in IDLE.
REQ-026 start while busy=1 is ignored.
REQ-027 start in the DONE cycle is ignored; a new start is accepted from IDLE only.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle.
REQ-029 Abort: no done pulse; match_cnt is left unchanged; det_clr=1 for that one transition cycle.
REQ-030 abort has priority over every other transition.
REQ-031 abort in IDLE has no effect.
REQ-032 Latency: start accepted at edge E0 -> done high in cycle 2 + FRAME_W*(1+GAP) after E0.
REQ-033 Example latency: 34 cycles for FRAME_W=16, GAP=1.
REQ-034 match_cnt holds its value until the next DONE.
REQ-035 match_cnt updates only in DONE.
REQ-036 All outputs are registered.

Reset
REQ-037 rst=0 -> immediately: state=IDLE, det_clr=0, det_valid=0, det_data=0, busy=0, done=0, match_cnt=0.
REQ-038 rst=0 also clears the shift register, bit counter, gap counter and running count.
REQ-039 Reset mid-frame discards the frame with no done pulse.
REQ-040 After rst returns to 1, the first start is accepted normally.

Verification
REQ-041 frame_in=16'hB000, GAP=1 -> done in cycle 34 after start, match_cnt=1.
REQ-042 frame_in=16'hB6C0 (overlapping matches) -> match_cnt=3.
REQ-043 frame_in=16'hBBBB -> match_cnt=4; frame_in=16'hFFFF -> match_cnt=0.
REQ-044 abort at the 5th SEND of a frame -> busy=0 next cycle, no done, det_clr pulses once, match_cnt keeps its prior value.
REQ-045 Second start while busy -> ignored; exactly one done pulse; det_valid pulses exactly FRAME_W times.
REQ-046 rst=0 mid-GAPW -> all outputs zero immediately; next start completes with the correct count.
